alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Shares the single 64-bit ALU between two requesters: port 0 = execute-stage OPq,
//  port 1 = address/stack-pointer adjust. Two-way round-robin arbitration, one op in flight.
//  Drives ALU_A/ALU_B/ALU_fun of the external ALU from registers and samples valE.
//  Returns a buffered result with valid/ready, and owns the Y86 condition codes ZF/SF/OF.
// PARAMETERS
//  WIDTH  64  operand/result width
//  FUN_W  4   ALU function code width; 0=ADD 1=SUB(A-B) 2=AND 3=XOR, 4..15 illegal
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      synchronous, active-low reset
//  req0_valid   in   1      port 0 request
//  req0_ready   out  1      port 0 accepted this cycle when valid&ready
//  req0_a/b     in   WIDTH  port 0 operands
//  req0_fun     in   FUN_W  port 0 function
//  req0_set_cc  in   1      update CC on completion (port 0 only)
//  req1_valid   in   1      port 1 request
//  req1_ready   out  1      port 1 accept
//  req1_a/b     in   WIDTH  port 1 operands
//  req1_fun     in   FUN_W  port 1 function (never updates CC)
//  alu_a/alu_b  out  WIDTH  registered drive to ALU_A/ALU_B
//  alu_fun      out  FUN_W  registered drive to ALU_fun
//  alu_vale     in   WIDTH  ALU valE, combinational from alu_a/b/fun
//  resp_valid   out  1      result available
//  resp_ready   in   1      consumer takes result when valid&ready
//  resp_id      out  1      requester that owns resp_vale
//  resp_vale    out  WIDTH  result
//  resp_err     out  1      fun was illegal (>3)
//  cc_zf/sf/of  out  1      condition codes
// BEHAVIOUR
//  Reset: state IDLE; all ready/resp_* = 0; alu_a/b/fun = 0; cc_zf=1, cc_sf=0, cc_of=0;
//   last_grant=1 (port 0 wins the first tie). Reset mid-op discards the op, no response.
//  FSM: IDLE -> EXEC on accept; EXEC -> RESP always (1 cycle);
//   RESP -> EXEC if resp_ready and a new accept; RESP -> IDLE if resp_ready, no accept;
//   RESP holds while !resp_ready.
//  Accept window: (state==IDLE) or (state==RESP && resp_ready). reqN_ready is high only in
//   that window and only for the granted port; at most one ready high per cycle.
//  Arbitration: one valid -> grant it; both valid -> grant port != last_grant; last_grant
//   updates only on accept. Ready never depends on the loser's valid.
//  On accept: alu_a/b/fun <= operands of granted port; latch id, set_cc (0 for port 1).
//   alu_* hold their value outside EXEC.
//  End of EXEC: resp_vale <= alu_vale (0 if illegal), resp_id, resp_err <= (fun>3),
//   resp_valid <= 1. Latency accept->resp_valid = 2 cycles; peak throughput 1 op / 2 cycles.
//  resp_* stable while resp_valid && !resp_ready; resp_valid drops the cycle after
//   handshake unless back-to-back op completes.
//  CC update (end of EXEC, only if set_cc && !illegal): ZF = (vale==0); SF = vale[W-1];
//   OF ADD = a[W-1]==b[W-1] && vale[W-1]!=a[W-1]; OF SUB = a[W-1]!=b[W-1] && vale[W-1]!=a[W-1];
//   OF AND/XOR = 0. Otherwise CC holds.
//  Width: all arithmetic modulo 2^WIDTH; no carry output.
// STRUCTURE
//  Shared header alu_defs.vh: ALU_ADD/SUB/AND/XOR codes, FSM state encodings
//   (IDLE/EXEC/RESP, 2 bits), reset CC constants.
//  Sub-module rr_arb2: 2-way round-robin grant with last_grant register and accept input.
//  CC next-value logic is a local function; ALU itself is instantiated outside this block.
// TESTING
//  Reset: after rst_n low 1 cycle -> cc_zf=1, sf=0, of=0, resp_valid=0, alu_a=0.
//  Port 0 ADD a=5 b=-5 set_cc=1 -> 2 cycles later resp_vale=0, id=0, ZF=1 SF=0 OF=0.
//  Port 0 ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 -> vale=0x8000_0000_0000_0000, SF=1 OF=1;
//   SUB a=0x8000...0 b=1 -> OF=1.
//  Both valid every cycle, resp_ready=1 -> grants 0,1,0,1 alternate; port 1 SUB never
//   changes CC.
//  resp_ready low 4 cycles in RESP -> resp_* stable, both req_ready=0, no new ALU drive.
//  fun=4'd7 on port 0 -> resp_err=1, resp_vale=0, CC unchanged; rst_n low during EXEC ->
//   no resp_valid afterwards.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: function codes, FSM states and
// the condition-code bundle with its reset value.
package alu_sched_pkg;

  localparam int FUN_ADD = 0;
  localparam int FUN_SUB = 1;
  localparam int FUN_AND = 2;
  localparam int FUN_XOR = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-way round-robin arbiter: grants only inside the accept window and
// remembers the last accepted port so ties alternate.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       window_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_o = 2'b00;
    if (window_i) begin
      if (valid_i[0] && (!valid_i[1] || last_q)) begin
        grant_o = 2'b01;
      end else if (valid_i[1]) begin
        grant_o = 2'b10;
      end
    end
  end

  // last_grant moves only when a grant is actually taken
  always_comb begin
    last_d = last_q;
    if (|grant_o) begin
      last_d = grant_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one external 64-bit ALU between the execute stage (port 0) and the
// address adjuster (port 1); one op in flight, buffered result, Y86 condition codes.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FUN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FUN_W-1:0] req0_fun,
  input  logic             req0_set_cc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FUN_W-1:0] req1_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FUN_W-1:0] alu_fun,
  input  logic [WIDTH-1:0] alu_vale,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_vale,
  output logic             resp_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [FUN_W-1:0] alu_fun_q;
  logic             id_q, set_cc_q;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_err_q;
  logic [WIDTH-1:0] resp_vale_q;
  cc_t              cc_q;

  logic       window;
  logic [1:0] grant;
  logic       accept;
  logic       illegal;

  function automatic cc_t cc_next(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] v,
                                  input logic [FUN_W-1:0] fun);
    cc_t c;
    c.zf = (v == '0);
    c.sf = v[WIDTH-1];
    c.of = 1'b0;
    if (fun == FUN_W'(FUN_ADD)) begin
      c.of = (a[WIDTH-1] == b[WIDTH-1]) && (v[WIDTH-1] != a[WIDTH-1]);
    end else if (fun == FUN_W'(FUN_SUB)) begin
      c.of = (a[WIDTH-1] != b[WIDTH-1]) && (v[WIDTH-1] != a[WIDTH-1]);
    end
    return c;
  endfunction

  assign window  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
  assign accept  = |grant;
  assign illegal = (alu_fun_q > FUN_W'(FUN_XOR));

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  ({req1_valid, req0_valid}),
    .window_i (window),
    .grant_o  (grant)
  );

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = accept ? ST_EXEC : ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fun_q    <= '0;
      id_q         <= 1'b0;
      set_cc_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_vale_q  <= '0;
      cc_q         <= CC_RST;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      if (accept) begin
        alu_a_q   <= grant[1] ? req1_a   : req0_a;
        alu_b_q   <= grant[1] ? req1_b   : req0_b;
        alu_fun_q <= grant[1] ? req1_fun : req0_fun;
        id_q      <= grant[1];
        set_cc_q  <= grant[0] && req0_set_cc;
      end
      // result capture at the end of the single EXEC cycle
      if (state_q == ST_EXEC) begin
        resp_vale_q <= illegal ? '0 : alu_vale;
        resp_id_q   <= id_q;
        resp_err_q  <= illegal;
        if (set_cc_q && !illegal) begin
          cc_q <= cc_next(alu_a_q, alu_b_q, alu_vale, alu_fun_q);
        end
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fun    = alu_fun_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_vale  = resp_vale_q;
  assign resp_err   = resp_err_q;
  assign cc_zf      = cc_q.zf;
  assign cc_sf      = cc_q.sf;
  assign cc_of      = cc_q.of;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural ALU, scoreboard of expected responses and
// condition codes, directed steps for latency, stall, arbitration and reset.
module tb_alu_sched;

  localparam int W  = 64;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_set_cc, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [FW-1:0] req0_fun, req1_fun;
  logic [W-1:0]  alu_a, alu_b, alu_vale, resp_vale;
  logic [FW-1:0] alu_fun;
  logic          resp_valid, resp_ready, resp_id, resp_err;
  logic          cc_zf, cc_sf, cc_of;

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(W), .FUN_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fun(req0_fun), .req0_set_cc(req0_set_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fun(req1_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_vale(alu_vale),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_vale(resp_vale), .resp_err(resp_err),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  // external ALU; illegal codes produce junk so the scheduler's zeroing is visible
  function automatic logic [W-1:0] env_alu(input logic [W-1:0] a, b, input logic [FW-1:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return a ^ b ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endcase
  endfunction
  assign alu_vale = env_alu(alu_a, alu_b, alu_fun);

  typedef struct {
    logic         id;
    logic [W-1:0] vale;
    logic         err;
    logic         zf, sf, of;
  } exp_t;

  exp_t sb_q[$];
  logic grant_log[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, b,
                                 input logic [FW-1:0] f, input logic sc);
    exp_t e;
    logic [W-1:0] v;
    case (f)
      4'd0:    v = a + b;
      4'd1:    v = a - b;
      4'd2:    v = a & b;
      4'd3:    v = a ^ b;
      default: v = '0;
    endcase
    e.id   = id;
    e.err  = (f > 4'd3);
    e.vale = v;
    if (!id && sc && !e.err) begin
      m_zf = (v == '0);
      m_sf = v[W-1];
      if (f == 4'd0)      m_of = (a[W-1] == b[W-1]) && (v[W-1] != a[W-1]);
      else if (f == 4'd1) m_of = (a[W-1] != b[W-1]) && (v[W-1] != a[W-1]);
      else                m_of = 1'b0;
    end
    e.zf = m_zf;
    e.sf = m_sf;
    e.of = m_of;
    return e;
  endfunction

  // monitor: pop/compare on response handshake, push on accept
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    end else begin
      if (resp_valid && resp_ready) begin
        chk("resp_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_id",   64'(resp_id),  64'(e.id));
          chk("sb_vale", resp_vale,     e.vale);
          chk("sb_err",  64'(resp_err), 64'(e.err));
          chk("sb_zf",   64'(cc_zf),    64'(e.zf));
          chk("sb_sf",   64'(cc_sf),    64'(e.sf));
          chk("sb_of",   64'(cc_of),    64'(e.of));
        end
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back(model(1'b0, req0_a, req0_b, req0_fun, req0_set_cc));
        grant_log.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back(model(1'b1, req1_a, req1_b, req1_fun, 1'b0));
        grant_log.push_back(1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit port, input logic [W-1:0] a, b,
                       input logic [FW-1:0] f, input logic sc);
    bit ok, rdy;
    ok = 1'b0;
    if (!port) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = f; req0_set_cc = sc;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = f;
    end
    for (int i = 0; i < 20; i++) begin
      #1 rdy = port ? req1_ready : req0_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("issue_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      if (sb_q.size() == 0 && !resp_valid) break;
      step();
    end
    chk("drained", 64'(sb_q.size() == 0 && !resp_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fun = '0; req0_set_cc = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fun = '0;
    step(); step();
    chk("rst_zf", 64'(cc_zf), 64'd1);
    chk("rst_sf", 64'(cc_sf), 64'd0);
    chk("rst_of", 64'(cc_of), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    rst_n = 1'b1;
    step();

    // latency and stall with consumer not ready
    issue(1'b0, 64'd5, -64'sd5, 4'd0, 1'b1);
    chk("lat_exec_no_valid", 64'(resp_valid), 64'd0);
    step();
    chk("lat_valid", 64'(resp_valid), 64'd1);
    chk("lat_vale", resp_vale, 64'd0);
    chk("lat_id", 64'(resp_id), 64'd0);
    chk("lat_zf", 64'(cc_zf), 64'd1);
    chk("lat_sf", 64'(cc_sf), 64'd0);
    chk("lat_of", 64'(cc_of), 64'd0);
    req0_valid = 1'b1; req0_a = 64'h1234; req0_fun = 4'd2;
    req1_valid = 1'b1; req1_a = 64'h5678;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_rdy0", 64'(req0_ready), 64'd0);
      chk("stall_rdy1", 64'(req1_ready), 64'd0);
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_vale", resp_vale, 64'd0);
      chk("stall_alu_a", alu_a, 64'd5);
      chk("stall_alu_fun", 64'(alu_fun), 64'd0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    wait_drain();

    // overflow cases
    issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 1'b1);
    wait_drain();
    chk("addov_sf", 64'(cc_sf), 64'd1);
    chk("addov_of", 64'(cc_of), 64'd1);
    issue(1'b0, 64'h8000_0000_0000_0000, 64'd1, 4'd1, 1'b1);
    wait_drain();
    chk("subov_of", 64'(cc_of), 64'd1);
    chk("subov_sf", 64'(cc_sf), 64'd0);

    // illegal function leaves CC alone
    issue(1'b0, 64'd3, 64'd3, 4'd7, 1'b1);
    wait_drain();
    chk("illegal_of_held", 64'(cc_of), 64'd1);
    chk("illegal_zf_held", 64'(cc_zf), 64'd0);
    issue(1'b0, 64'hF0, 64'h0F, 4'd2, 1'b1);
    issue(1'b0, 64'h8000_0000_0000_0001, 64'd1, 4'd3, 1'b0);
    wait_drain();
    chk("and_zf", 64'(cc_zf), 64'd1);

    // round-robin under continuous contention, from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_log.delete();
    req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4; req0_fun = 4'd0; req0_set_cc = 1'b1;
    req1_valid = 1'b1; req1_a = 64'd0; req1_b = 64'd1; req1_fun = 4'd1;
    for (int i = 0; i < 40; i++) begin
      if (grant_log.size() >= 4) break;
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", 64'(grant_log.size() >= 4), 64'd1);
    if (grant_log.size() >= 4) begin
      chk("rr_g0", 64'(grant_log[0]), 64'd0);
      chk("rr_g1", 64'(grant_log[1]), 64'd1);
      chk("rr_g2", 64'(grant_log[2]), 64'd0);
      chk("rr_g3", 64'(grant_log[3]), 64'd1);
    end
    wait_drain();
    chk("rr_sf_port1_no_cc", 64'(cc_sf), 64'd0);

    // reset during EXEC drops the op
    issue(1'b0, 64'd1, 64'd1, 4'd0, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("midrst_no_valid", 64'(resp_valid), 64'd0);
      step();
    end
    chk("midrst_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("midrst_zf", 64'(cc_zf), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
